// File: rtl/mem_stage_hs.sv
// Handshaked MEM stage: formats loads/stores for a variable-latency data memory, tracks LL/SC links, flags misalignment and timeouts.
// Latency: non-memory/misaligned/failed-SC ops reach WB 1 cycle after accept; memory ops 1 cycle after dm_ack (min 2 cycles).
// Backpressure: in_ready is low from the cycle after a memory op is accepted until the cycle after dm_ack or timeout.
module mem_stage_hs #(
   parameter int ADDR_W  = 32,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_sdata,
   input  logic [REG_AW-1:0] in_wreg,
   input  logic              in_regwrite,
   input  logic              in_memread,
   input  logic              in_memwrite,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wdata,
   output logic [3:0]        dm_be,
   input  logic              dm_ack,
   input  logic [31:0]       dm_rdata,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_reg,
   output logic              wb_regwrite,
   output logic [31:0]       wb_data,
   output logic              exc_align,
   output logic              exc_timeout
);

   localparam logic [5:0] OP_LB   = 6'b100001;
   localparam logic [5:0] OP_LBU  = 6'b101010;
   localparam logic [5:0] OP_LH   = 6'b101011;
   localparam logic [5:0] OP_LHU  = 6'b101100;
   localparam logic [5:0] OP_LW   = 6'b111101;
   localparam logic [5:0] OP_LL   = 6'b101000;
   localparam logic [5:0] OP_LWC1 = 6'b110101;
   localparam logic [5:0] OP_LWL  = 6'b101101;
   localparam logic [5:0] OP_LWR  = 6'b101110;
   localparam logic [5:0] OP_SB   = 6'b101111;
   localparam logic [5:0] OP_SH   = 6'b110000;
   localparam logic [5:0] OP_SW   = 6'b110001;
   localparam logic [5:0] OP_SC   = 6'b110110;
   localparam logic [5:0] OP_SWL  = 6'b110010;
   localparam logic [5:0] OP_SWR  = 6'b110011;

   // Last wait cycle index: dm_req stays up for exactly TIMEOUT cycles without an ack.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t              state_q;
   logic                in_ready_q;
   logic [15:0]         cnt_q;
   logic [5:0]          op_q;
   logic [1:0]          k_q;
   logic [31:0]         sdata_q;
   logic                rw_q;
   logic                sc_q;
   logic                link_valid_q;
   logic [ADDR_W-1:0]   link_addr_q;
   logic                dm_req_q;
   logic                dm_we_q;
   logic [ADDR_W-1:0]   dm_addr_q;
   logic [31:0]         dm_wdata_q;
   logic [3:0]          dm_be_q;
   logic                wb_valid_q;
   logic [REG_AW-1:0]   wb_reg_q;
   logic                wb_regwrite_q;
   logic [31:0]         wb_data_q;
   logic                exc_align_q;
   logic                exc_timeout_q;

   logic                ld_d;
   logic                st_d;
   logic                mem_d;
   logic                odd_d;
   logic                mis_d;
   logic                is_sc_d;
   logic                link_hit_d;
   logic [1:0]          k_d;
   logic [3:0]          be_d;
   logic [31:0]         wdata_d;
   logic [ADDR_W-1:0]   wa_d;

   assign in_ready    = in_ready_q;
   assign dm_req      = dm_req_q;
   assign dm_we       = dm_we_q;
   assign dm_addr     = dm_addr_q;
   assign dm_wdata    = dm_wdata_q;
   assign dm_be       = dm_be_q;
   assign wb_valid    = wb_valid_q;
   assign wb_reg      = wb_reg_q;
   assign wb_regwrite = wb_regwrite_q;
   assign wb_data     = wb_data_q;
   assign exc_align   = exc_align_q;
   assign exc_timeout = exc_timeout_q;

   // Big-endian load formatting: byte offset k lives at bits [31-8k -: 8].
   function automatic logic [31:0] fmt_load(input logic [5:0] op, input logic [1:0] k,
                                            input logic [31:0] rd, input logic [31:0] sd);
      logic [31:0] up;
      logic [31:0] dn;
      logic [31:0] m;
      up = rd << {k, 3'b000};
      dn = rd >> {(2'd3 - k), 3'b000};
      fmt_load = rd;
      case (op)
         OP_LB:   fmt_load = {{24{up[31]}}, up[31:24]};
         OP_LBU:  fmt_load = {24'd0, up[31:24]};
         OP_LH:   fmt_load = {{16{up[31]}}, up[31:16]};
         OP_LHU:  fmt_load = {16'd0, up[31:16]};
         OP_LWL: begin
            m = (32'd1 << {k, 3'b000}) - 32'd1;
            fmt_load = up | (sd & m);
         end
         OP_LWR: begin
            m = ~(32'hFFFF_FFFF >> {(2'd3 - k), 3'b000});
            fmt_load = dn | (sd & m);
         end
         default: fmt_load = rd;
      endcase
   endfunction

   // Decode the incoming op: load/store class, alignment, lane enables and lane-positioned data.
   always_comb begin
      k_d     = in_addr[1:0];
      ld_d    = 1'b0;
      st_d    = 1'b0;
      odd_d   = 1'b0;
      be_d    = 4'b0000;
      wdata_d = 32'd0;
      case (in_op)
         OP_LB, OP_LBU, OP_LWL, OP_LWR: ld_d = in_memread;
         OP_LH, OP_LHU: begin
            ld_d  = in_memread;
            odd_d = in_addr[0];
         end
         OP_LW, OP_LL, OP_LWC1: begin
            ld_d  = in_memread;
            odd_d = (k_d != 2'd0);
         end
         OP_SB: begin
            st_d    = in_memwrite;
            be_d    = 4'b1000 >> k_d;
            wdata_d = {4{in_sdata[7:0]}};
         end
         OP_SH: begin
            st_d    = in_memwrite;
            odd_d   = in_addr[0];
            be_d    = 4'b1100 >> k_d;
            wdata_d = {2{in_sdata[15:0]}};
         end
         OP_SW, OP_SC: begin
            st_d    = in_memwrite;
            odd_d   = (k_d != 2'd0);
            be_d    = 4'b1111;
            wdata_d = in_sdata;
         end
         OP_SWL: begin
            st_d    = in_memwrite;
            be_d    = 4'b1111 >> k_d;
            wdata_d = in_sdata >> {k_d, 3'b000};
         end
         OP_SWR: begin
            st_d    = in_memwrite;
            be_d    = 4'b1111 << (2'd3 - k_d);
            wdata_d = in_sdata << {(2'd3 - k_d), 3'b000};
         end
         default: ;
      endcase
      mem_d      = ld_d | st_d;
      mis_d      = mem_d & odd_d;
      is_sc_d    = st_d & (in_op == OP_SC);
      wa_d       = {in_addr[ADDR_W-1:2], 2'b00};
      link_hit_d = link_valid_q && (link_addr_q == wa_d);
   end

   // Stage FSM: accept in IDLE, hold the request stable in ACCESS, emit one registered WB pulse.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= S_IDLE;
         in_ready_q    <= 1'b1;
         cnt_q         <= 16'd0;
         op_q          <= 6'd0;
         k_q           <= 2'd0;
         sdata_q       <= 32'd0;
         rw_q          <= 1'b0;
         sc_q          <= 1'b0;
         link_valid_q  <= 1'b0;
         link_addr_q   <= '0;
         dm_req_q      <= 1'b0;
         dm_we_q       <= 1'b0;
         dm_addr_q     <= '0;
         dm_wdata_q    <= 32'd0;
         dm_be_q       <= 4'd0;
         wb_valid_q    <= 1'b0;
         wb_reg_q      <= '0;
         wb_regwrite_q <= 1'b0;
         wb_data_q     <= 32'd0;
         exc_align_q   <= 1'b0;
         exc_timeout_q <= 1'b0;
      end else begin
         wb_valid_q    <= 1'b0;
         wb_regwrite_q <= 1'b0;
         exc_align_q   <= 1'b0;
         exc_timeout_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  wb_reg_q <= in_wreg;
                  // Every SC consumes the link, whether or not it succeeds.
                  if (is_sc_d) link_valid_q <= 1'b0;
                  if (!mem_d || mis_d) begin
                     wb_valid_q    <= 1'b1;
                     wb_regwrite_q <= in_regwrite & ~mis_d;
                     wb_data_q     <= 32'(in_addr);
                     exc_align_q   <= mis_d;
                  end else if (is_sc_d && !link_hit_d) begin
                     wb_valid_q    <= 1'b1;
                     wb_regwrite_q <= in_regwrite;
                     wb_data_q     <= 32'd0;
                  end else begin
                     state_q    <= S_ACCESS;
                     in_ready_q <= 1'b0;
                     cnt_q      <= 16'd0;
                     op_q       <= in_op;
                     k_q        <= k_d;
                     sdata_q    <= in_sdata;
                     rw_q       <= in_regwrite;
                     sc_q       <= is_sc_d;
                     dm_req_q   <= 1'b1;
                     dm_we_q    <= st_d;
                     dm_addr_q  <= wa_d;
                     dm_be_q    <= be_d;
                     dm_wdata_q <= wdata_d;
                  end
               end
            end
            S_ACCESS: begin
               if (dm_ack) begin
                  state_q       <= S_IDLE;
                  in_ready_q    <= 1'b1;
                  dm_req_q      <= 1'b0;
                  wb_valid_q    <= 1'b1;
                  wb_regwrite_q <= rw_q;
                  if (sc_q)
                     wb_data_q <= 32'd1;
                  else if (!dm_we_q)
                     wb_data_q <= fmt_load(op_q, k_q, dm_rdata, sdata_q);
                  else
                     wb_data_q <= 32'({dm_addr_q[ADDR_W-1:2], k_q});
                  if (!dm_we_q && (op_q == OP_LL)) begin
                     link_valid_q <= 1'b1;
                     link_addr_q  <= dm_addr_q;
                  end
                  if (dm_we_q && (link_addr_q == dm_addr_q)) link_valid_q <= 1'b0;
               end else if (cnt_q == TO_LAST) begin
                  state_q       <= S_IDLE;
                  in_ready_q    <= 1'b1;
                  dm_req_q      <= 1'b0;
                  wb_valid_q    <= 1'b1;
                  wb_regwrite_q <= 1'b0;
                  wb_data_q     <= 32'({dm_addr_q[ADDR_W-1:2], k_q});
                  exc_timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed vector table, hand-written multi-cycle sequences, then random ops vs a lane-level model.
// Latency: each op is driven to completion before the next; the bench acts as a variable-latency memory.
// Backpressure: the memory responder chooses the ack delay per op (or withholds it to force a timeout).
module tb_mem_stage_hs;
   localparam int TO = 6;
   localparam int NO_ACK = 99;

   localparam logic [5:0] OP_LB   = 6'b100001;
   localparam logic [5:0] OP_LBU  = 6'b101010;
   localparam logic [5:0] OP_LH   = 6'b101011;
   localparam logic [5:0] OP_LHU  = 6'b101100;
   localparam logic [5:0] OP_LW   = 6'b111101;
   localparam logic [5:0] OP_LL   = 6'b101000;
   localparam logic [5:0] OP_LWC1 = 6'b110101;
   localparam logic [5:0] OP_LWL  = 6'b101101;
   localparam logic [5:0] OP_LWR  = 6'b101110;
   localparam logic [5:0] OP_SB   = 6'b101111;
   localparam logic [5:0] OP_SH   = 6'b110000;
   localparam logic [5:0] OP_SW   = 6'b110001;
   localparam logic [5:0] OP_SC   = 6'b110110;
   localparam logic [5:0] OP_SWL  = 6'b110010;
   localparam logic [5:0] OP_SWR  = 6'b110011;

   logic        CLK, RESET;
   logic        in_valid, in_ready;
   logic [5:0]  in_op;
   logic [31:0] in_addr, in_sdata;
   logic [4:0]  in_wreg;
   logic        in_regwrite, in_memread, in_memwrite;
   logic        dm_req, dm_we, dm_ack;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic        wb_valid, wb_regwrite, exc_align, exc_timeout;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;

   int checks = 0;
   int failures = 0;
   logic        m_lv;
   logic [31:0] m_la;

   typedef struct {
      int req_cycles; int wb_cnt; int lat; int ready_low; bit stable_bad;
      logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
      logic [31:0] wb_data; logic [4:0] wb_reg; logic rw; logic align; logic to;
   } obs_t;

   typedef struct {
      bit req; bit we; bit chk_wd; bit chk_wb; logic rw; logic align; logic to;
      logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic [31:0] wb_data; logic [4:0] wreg;
   } exp_t;

   typedef struct {
      logic [5:0] op; logic [31:0] addr; logic [31:0] sdata; logic [31:0] rdata;
      logic mr; logic mw; logic [3:0] be; logic [31:0] wdata; logic [31:0] wb;
   } vec_t;

   mem_stage_hs #(.ADDR_W(32), .REG_AW(5), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_addr(in_addr), .in_sdata(in_sdata), .in_wreg(in_wreg), .in_regwrite(in_regwrite),
      .in_memread(in_memread), .in_memwrite(in_memwrite), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
      .exc_align(exc_align), .exc_timeout(exc_timeout));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] byte_at(input logic [31:0] w, input int i);
      byte_at = w[31-8*i -: 8];
   endfunction

   // Issue one op at the current negedge and play memory until its single WB pulse has passed.
   task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wreg, input logic rw, input logic mr, input logic mw,
                         input int dly, input logic [31:0] rdata, output obs_t o);
      bit done;
      o.req_cycles = 0; o.wb_cnt = 0; o.lat = 0; o.ready_low = 0; o.stable_bad = 0;
      o.we = 0; o.addr = 0; o.be = 0; o.wdata = 0; o.wb_data = 0; o.wb_reg = 0;
      o.rw = 0; o.align = 0; o.to = 0;
      in_op = op; in_addr = addr; in_sdata = sdata; in_wreg = wreg;
      in_regwrite = rw; in_memread = mr; in_memwrite = mw; in_valid = 1'b1;
      done = 0;
      for (int n = 1; n <= 40 && !done; n++) begin
         @(negedge CLK);
         if (n == 1) in_valid = 1'b0;
         if (!in_ready) o.ready_low++;
         if (wb_valid) begin
            o.wb_cnt++;
            if (o.wb_cnt == 1) begin
               o.lat = n; o.wb_data = wb_data; o.wb_reg = wb_reg;
               o.rw = wb_regwrite; o.align = exc_align; o.to = exc_timeout;
            end
         end else if (o.wb_cnt > 0) begin
            done = 1;
         end
         if (dm_req) begin
            if (o.req_cycles == 0) begin
               o.we = dm_we; o.addr = dm_addr; o.be = dm_be; o.wdata = dm_wdata;
            end else if (dm_we !== o.we || dm_addr !== o.addr || dm_be !== o.be || dm_wdata !== o.wdata) begin
               o.stable_bad = 1;
            end
            o.req_cycles++;
            dm_ack = (o.req_cycles - 1 == dly);
            dm_rdata = rdata;
         end else begin
            dm_ack = 1'b0;
            dm_rdata = 32'd0;
         end
      end
      dm_ack = 1'b0;
   endtask

   // Reference model: expected memory request and WB result from byte-lane rules and a link flag.
   task automatic model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] wreg, input logic rw, input logic mr, input logic mw,
                        input int dly, input logic [31:0] rdata, output exp_t e);
      int k;
      bit ld, st, mis, sc, hit;
      logic [7:0] b[4];
      logic [7:0] s[4];
      logic [7:0] r[4];
      logic [7:0] wl[4];
      k = int'(addr[1:0]);
      for (int i = 0; i < 4; i++) begin b[i] = byte_at(rdata, i); s[i] = byte_at(sdata, i); wl[i] = 8'd0; end
      ld = mr && (op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_LWC1, OP_LWL, OP_LWR});
      st = mw && (op inside {OP_SB, OP_SH, OP_SW, OP_SC, OP_SWL, OP_SWR});
      mis = ((op inside {OP_LH, OP_LHU, OP_SH}) && (k % 2 == 1)) ||
            ((op inside {OP_LW, OP_LL, OP_LWC1, OP_SW, OP_SC}) && k != 0);
      e.req = 0; e.we = st; e.chk_wd = st; e.chk_wb = 1; e.rw = rw; e.align = 0; e.to = 0;
      e.addr = addr & 32'hFFFF_FFFC; e.be = 4'd0; e.wdata = 32'd0; e.wb_data = addr; e.wreg = wreg;
      if (!(ld || st)) return;
      sc = st && (op == OP_SC);
      hit = 0;
      if (sc) begin hit = m_lv && (m_la == e.addr); m_lv = 0; end
      if (mis) begin e.rw = 0; e.align = 1; return; end
      if (sc && !hit) begin e.wb_data = 32'd0; return; end
      e.req = 1;
      if (st) begin
         for (int j = 0; j < 4; j++) begin
            case (op)
               OP_SB:  if (j == k) begin e.be[3-j] = 1; end
               OP_SH:  if (j == k || j == k + 1) begin e.be[3-j] = 1; end
               OP_SWL: if (j >= k) begin e.be[3-j] = 1; wl[j] = s[j-k]; end
               OP_SWR: if (j <= k) begin e.be[3-j] = 1; wl[j] = s[j+3-k]; end
               default: begin e.be[3-j] = 1; wl[j] = s[j]; end
            endcase
         end
         if (op == OP_SB) e.wdata = {s[3], s[3], s[3], s[3]};
         else if (op == OP_SH) e.wdata = {s[2], s[3], s[2], s[3]};
         else e.wdata = {wl[0], wl[1], wl[2], wl[3]};
      end
      if (dly >= TO) begin e.to = 1; e.rw = 0; e.chk_wb = 0; return; end
      if (ld && op == OP_LL) begin m_lv = 1; m_la = e.addr; end
      if (st && m_la == e.addr) m_lv = 0;
      if (sc) e.wb_data = 32'd1;
      else if (st) e.chk_wb = 0;
      else begin
         for (int i = 0; i < 4; i++) r[i] = b[i];
         case (op)
            OP_LB:  e.wb_data = {{24{b[k][7]}}, b[k]};
            OP_LBU: e.wb_data = {24'd0, b[k]};
            OP_LH:  e.wb_data = {{16{b[k][7]}}, b[k], b[k+1]};
            OP_LHU: e.wb_data = {16'd0, b[k], b[k+1]};
            OP_LWL: begin
               for (int i = 0; i < 4; i++) r[i] = (i + k <= 3) ? b[i+k] : s[i];
               e.wb_data = {r[0], r[1], r[2], r[3]};
            end
            OP_LWR: begin
               for (int i = 0; i < 4; i++) r[i] = (i >= 3 - k) ? b[i-(3-k)] : s[i];
               e.wb_data = {r[0], r[1], r[2], r[3]};
            end
            default: e.wb_data = rdata;
         endcase
      end
   endtask

   task automatic compare(input string tag, input exp_t e, input obs_t o);
      chk({tag, " req"}, 32'(o.req_cycles != 0), 32'(e.req));
      if (e.req) begin
         chk({tag, " we"}, 32'(o.we), 32'(e.we));
         chk({tag, " addr"}, o.addr, e.addr);
         chk({tag, " be"}, 32'(o.be), 32'(e.be));
         if (e.chk_wd) chk({tag, " wdata"}, o.wdata, e.wdata);
         chk({tag, " stable"}, 32'(o.stable_bad), 32'd0);
         if (e.to) chk({tag, " req_cycles"}, 32'(o.req_cycles), 32'(TO));
      end
      chk({tag, " wb_cnt"}, 32'(o.wb_cnt), 32'd1);
      chk({tag, " wb_reg"}, 32'(o.wb_reg), 32'(e.wreg));
      chk({tag, " wb_regwrite"}, 32'(o.rw), 32'(e.rw));
      chk({tag, " exc_align"}, 32'(o.align), 32'(e.align));
      chk({tag, " exc_timeout"}, 32'(o.to), 32'(e.to));
      if (e.chk_wb) chk({tag, " wb_data"}, o.wb_data, e.wb_data);
   endtask

   initial begin
      vec_t tbl[16];
      obs_t o;
      exp_t e;
      logic [5:0] ops[16];
      logic [5:0] op;
      logic [31:0] a;
      logic mr, mw, rw;
      int dly;

      tbl[0]  = '{OP_LB,   32'h1003, 32'h0,        32'h112233F4, 1, 0, 4'b0000, 32'h0,        32'hFFFFFFF4};
      tbl[1]  = '{OP_LBU,  32'h1003, 32'h0,        32'h112233F4, 1, 0, 4'b0000, 32'h0,        32'h000000F4};
      tbl[2]  = '{OP_LH,   32'h2002, 32'h0,        32'h1234ABCD, 1, 0, 4'b0000, 32'h0,        32'hFFFFABCD};
      tbl[3]  = '{OP_LHU,  32'h2000, 32'h0,        32'h80011234, 1, 0, 4'b0000, 32'h0,        32'h00008001};
      tbl[4]  = '{OP_LW,   32'h4000, 32'h0,        32'hCAFEF00D, 1, 0, 4'b0000, 32'h0,        32'hCAFEF00D};
      tbl[5]  = '{OP_LWL,  32'h1001, 32'h11223344, 32'hAABBCCDD, 1, 0, 4'b0000, 32'h0,        32'hBBCCDD44};
      tbl[6]  = '{OP_LWR,  32'h1001, 32'h11223344, 32'hAABBCCDD, 1, 0, 4'b0000, 32'h0,        32'h1122AABB};
      tbl[7]  = '{OP_LWL,  32'h1003, 32'h11223344, 32'hAABBCCDD, 1, 0, 4'b0000, 32'h0,        32'hDD223344};
      tbl[8]  = '{OP_LWR,  32'h1003, 32'h11223344, 32'hAABBCCDD, 1, 0, 4'b0000, 32'h0,        32'hAABBCCDD};
      tbl[9]  = '{OP_SB,   32'h1001, 32'h0000005A, 32'h0,        0, 1, 4'b0100, 32'h5A5A5A5A, 32'h0};
      tbl[10] = '{OP_SH,   32'h2002, 32'h0000ABCD, 32'h0,        0, 1, 4'b0011, 32'hABCDABCD, 32'h0};
      tbl[11] = '{OP_SW,   32'h4004, 32'h11223344, 32'h0,        0, 1, 4'b1111, 32'h11223344, 32'h0};
      tbl[12] = '{OP_SWL,  32'h1002, 32'h11223344, 32'h0,        0, 1, 4'b0011, 32'h00001122, 32'h0};
      tbl[13] = '{OP_SWR,  32'h1001, 32'h11223344, 32'h0,        0, 1, 4'b1100, 32'h33440000, 32'h0};
      tbl[14] = '{OP_LB,   32'h1000, 32'h0,        32'h7F000000, 1, 0, 4'b0000, 32'h0,        32'h0000007F};
      tbl[15] = '{OP_SWL,  32'h1000, 32'h11223344, 32'h0,        0, 1, 4'b1111, 32'h11223344, 32'h0};

      RESET = 1'b0; in_valid = 0; in_op = 0; in_addr = 0; in_sdata = 0; in_wreg = 0;
      in_regwrite = 0; in_memread = 0; in_memwrite = 0; dm_ack = 0; dm_rdata = 0;
      m_lv = 0; m_la = 0;
      repeat (3) @(negedge CLK);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst dm_req", 32'(dm_req), 32'd0);
      chk("rst dm_we/be", 32'({dm_we, dm_be}), 32'd0);
      chk("rst dm_addr", dm_addr, 32'd0);
      chk("rst dm_wdata", dm_wdata, 32'd0);
      chk("rst wb_valid/rw/exc", 32'({wb_valid, wb_regwrite, exc_align, exc_timeout}), 32'd0);
      chk("rst wb_data", wb_data, 32'd0);
      chk("rst wb_reg", 32'(wb_reg), 32'd0);
      RESET = 1'b1;
      @(negedge CLK);

      // Directed vector table, same-cycle ack.
      for (int i = 0; i < 16; i++) begin
         run_op(tbl[i].op, tbl[i].addr, tbl[i].sdata, 5'd3, tbl[i].mr, tbl[i].mr, tbl[i].mw, 0, tbl[i].rdata, o);
         chk($sformatf("vec%0d req", i), 32'(o.req_cycles), 32'd1);
         chk($sformatf("vec%0d we", i), 32'(o.we), 32'(tbl[i].mw));
         chk($sformatf("vec%0d addr", i), o.addr, tbl[i].addr & 32'hFFFF_FFFC);
         chk($sformatf("vec%0d be", i), 32'(o.be), 32'(tbl[i].be));
         if (tbl[i].mw) chk($sformatf("vec%0d wdata", i), o.wdata, tbl[i].wdata);
         else chk($sformatf("vec%0d wb_data", i), o.wb_data, tbl[i].wb);
         chk($sformatf("vec%0d lat", i), 32'(o.lat), 32'd2);
         chk($sformatf("vec%0d wb_cnt", i), 32'(o.wb_cnt), 32'd1);
      end

      // Non-memory op passes the ALU result through in one cycle.
      run_op(6'b000000, 32'hDEAD0001, 32'h0, 5'd9, 1, 0, 0, 0, 32'h0, o);
      chk("alu req", 32'(o.req_cycles), 32'd0);
      chk("alu wb_data", o.wb_data, 32'hDEAD0001);
      chk("alu lat", 32'(o.lat), 32'd1);
      chk("alu rw", 32'(o.rw), 32'd1);

      // Ack delayed 5 cycles: also lands on the final timeout cycle, where ack must win.
      run_op(OP_LW, 32'h5000, 32'h0, 5'd4, 1, 1, 0, 5, 32'h01020304, o);
      chk("dly5 ready_low", 32'(o.ready_low), 32'd6);
      chk("dly5 stable", 32'(o.stable_bad), 32'd0);
      chk("dly5 lat", 32'(o.lat), 32'd7);
      chk("dly5 wb_cnt", 32'(o.wb_cnt), 32'd1);
      chk("dly5 wb_data", o.wb_data, 32'h01020304);
      chk("dly5 timeout", 32'(o.to), 32'd0);

      // No ack: timeout, then a stray ack in IDLE must be ignored.
      run_op(OP_LW, 32'h5004, 32'h0, 5'd5, 1, 1, 0, NO_ACK, 32'h0, o);
      chk("to exc_timeout", 32'(o.to), 32'd1);
      chk("to regwrite", 32'(o.rw), 32'd0);
      chk("to req_cycles", 32'(o.req_cycles), 32'(TO));
      chk("to wb_cnt", 32'(o.wb_cnt), 32'd1);
      dm_ack = 1'b1;
      @(negedge CLK);
      dm_ack = 1'b0;
      chk("late ack wb_valid", 32'(wb_valid), 32'd0);
      chk("late ack in_ready", 32'(in_ready), 32'd1);
      @(negedge CLK);
      chk("late ack wb_valid2", 32'(wb_valid), 32'd0);

      // LL/SC pair, repeated SC, misaligned LW.
      run_op(OP_LL, 32'h3000, 32'h0, 5'd6, 1, 1, 0, 1, 32'h00000042, o);
      chk("ll wb_data", o.wb_data, 32'h00000042);
      run_op(OP_SC, 32'h3000, 32'h77, 5'd6, 1, 0, 1, 0, 32'h0, o);
      chk("sc1 req", 32'(o.req_cycles), 32'd1);
      chk("sc1 we", 32'(o.we), 32'd1);
      chk("sc1 wb_data", o.wb_data, 32'd1);
      run_op(OP_SC, 32'h3000, 32'h77, 5'd6, 1, 0, 1, 0, 32'h0, o);
      chk("sc2 req", 32'(o.req_cycles), 32'd0);
      chk("sc2 wb_data", o.wb_data, 32'd0);
      chk("sc2 lat", 32'(o.lat), 32'd1);
      run_op(OP_LW, 32'h3002, 32'h0, 5'd7, 1, 1, 0, 0, 32'h0, o);
      chk("mis exc_align", 32'(o.align), 32'd1);
      chk("mis req", 32'(o.req_cycles), 32'd0);
      chk("mis regwrite", 32'(o.rw), 32'd0);

      // Reset in the middle of an access clears the request and the link.
      run_op(OP_LL, 32'h3000, 32'h0, 5'd6, 1, 1, 0, 0, 32'h0, o);
      in_op = OP_LW; in_addr = 32'h3004; in_memread = 1; in_memwrite = 0; in_valid = 1;
      @(negedge CLK);
      in_valid = 0;
      @(negedge CLK);
      chk("mid dm_req before", 32'(dm_req), 32'd1);
      #2 RESET = 1'b0;
      #1;
      chk("mid dm_req async", 32'(dm_req), 32'd0);
      chk("mid in_ready async", 32'(in_ready), 32'd1);
      @(negedge CLK);
      RESET = 1'b1;
      begin
         int wbs;
         wbs = 0;
         for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (wb_valid || dm_req) wbs++;
         end
         chk("mid no wb/req", 32'(wbs), 32'd0);
      end
      run_op(OP_SC, 32'h3000, 32'h1, 5'd6, 1, 0, 1, 0, 32'h0, o);
      chk("mid sc req", 32'(o.req_cycles), 32'd0);
      chk("mid sc wb_data", o.wb_data, 32'd0);

      // Random ops against the model.
      ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_LWC1, OP_LWL,
              OP_LWR, OP_SB, OP_SH, OP_SW, OP_SC, OP_SWL, OP_SWR, 6'd0};
      m_lv = 0;
      for (int it = 0; it < 300; it++) begin
         int sel;
         logic [31:0] sd, rd;
         logic [4:0] wr;
         sel = $urandom_range(0, 15);
         op = ops[sel];
         mr = (sel <= 8);
         mw = (sel >= 9 && sel <= 14);
         if (sel == 15) op = 6'($urandom);
         a = 32'h3000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
         sd = $urandom; rd = $urandom; wr = 5'($urandom);
         rw = mr || op == OP_SC || 1'($urandom);
         dly = ($urandom_range(0, 9) > 7) ? NO_ACK : $urandom_range(0, TO - 1);
         model(op, a, sd, wr, rw, mr, mw, dly, rd, e);
         run_op(op, a, sd, wr, rw, mr, mw, dly, rd, o);
         compare($sformatf("rnd%0d op=%b", it, op), e, o);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
